multicycle_control_fsm: RTL and testbench

Multicycle sequencer for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back states, driving the shared ALU, the unified memory and the register file one cycle at a time. It supports R-type, lw, sw, andi, ori, addi, beq and bne, and stalls on a memory ready handshake. It sits between the instruction register and the datapath muxes and write enables.

---
 rtl/multicycle_control_fsm.sv | 256 +++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multicycle MIPS control sequencer. It steps each instruction through
//   FETCH/DECODE/EXEC/MEM/WB states and drives the datapath mux selects and
//   write enables. Memory states stall on the mem_ready handshake.
//
// Parameters
//   MEM_TIMEOUT  wait-cycle limit in a memory state (2..255). Only used when
//                MEM_TIMEOUT_EN is defined.
//
// Optional feature
//   `define MEM_TIMEOUT_EN  builds an 8-bit wait counter. A memory wait that
//                           reaches MEM_TIMEOUT cycles aborts back to FETCH
//                           and pulses mem_timeout.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode            IR opcode, sampled in DECODE (latched into op_q)
//   zero              ALU zero flag, used in BRANCH
//   mem_ready         memory access completes this cycle
//   pc_write..alu_op  datapath enables and mux selects (Moore-decoded, with
//                     mem_ready/zero qualifiers)
//   pc_source         00 = ALU result, 01 = ALUOut
//   state             current state encoding (debug)
//   instr_done        pulse in the last cycle of each completed instruction
//   illegal_op        pulse in DECODE on an unsupported opcode
//   mem_timeout       pulse on a memory wait abort (0 without MEM_TIMEOUT_EN)
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    I_EXEC    = 4'd9,
    I_WB      = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       wait_abort;   // current wait-state cycle hits the timeout
  logic       taken;

  // ---------------------------------------------------------------------
  // Wait-state timeout
  // ---------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       in_wait;

  assign in_wait    = (state_q == FETCH) || (state_q == MEM_READ) ||
                      (state_q == MEM_WRITE);
  assign wait_abort = in_wait && !mem_ready && (wait_cnt == TMO_LAST);

  // An abort from FETCH re-enters FETCH, so it must clear the counter even
  // though the state encoding does not change.
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if (state_d != state_q || wait_abort)
      wait_cnt <= '0;
    else if (in_wait && !mem_ready)
      wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign wait_abort = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State and opcode registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
    end
  end

  assign taken = (op_q == OP_BNE) ? !zero : zero;
  assign state = reset ? 4'd0 : state_q;

  // ---------------------------------------------------------------------
  // Next state and output decode. Everything is forced to 0 while reset
  // is high, so an access in flight sees no strobe or write enable.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_source   = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end else if (wait_abort) begin
            mem_timeout = 1'b1;
            state_d     = FETCH;
          end
        end

        DECODE: begin
          // Branch target is computed now so BRANCH can select ALUOut.
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW:             state_d = MEM_ADDR;
            OP_RTYPE:                 state_d = R_EXEC;
            OP_BEQ, OP_BNE:           state_d = BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: state_d = I_EXEC;
            default: begin
              illegal_op = 1'b1;
              state_d    = FETCH;
            end
          endcase
        end

        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
        end

        MEM_READ: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            state_d = MEM_WB;
          end else if (wait_abort) begin
            mem_timeout = 1'b1;
            state_d     = FETCH;
          end
        end

        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end

        MEM_WRITE: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end else if (wait_abort) begin
            mem_timeout = 1'b1;
            state_d     = FETCH;
          end
        end

        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = R_WB;
        end

        R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end

        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_source  = 2'b01;
          pc_write   = taken;
          instr_done = 1'b1;
          state_d    = FETCH;
        end

        I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
          state_d   = I_WB;
        end

        I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end

        default: state_d = FETCH;   // unreachable encodings 11..15
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm (default build, no timeout).
// Each stimulus cycle pushes the hand-derived expected output vector; a
// monitor on the falling edge pops and compares the full DUT output set.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, iod, mrd, mwr, rdst, m2r, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic       done, ill, tmo;
  } exp_t;

  localparam exp_t E_ZERO    = '0;
  localparam exp_t E_FETCH_W = '{st:4'd0, mrd:1'b1, asb:2'b01, default:'0};
  localparam exp_t E_FETCH_G = '{st:4'd0, pcw:1'b1, irw:1'b1, mrd:1'b1, asb:2'b01, default:'0};
  localparam exp_t E_DEC     = '{st:4'd1, asb:2'b11, default:'0};
  localparam exp_t E_DEC_ILL = '{st:4'd1, asb:2'b11, ill:1'b1, default:'0};
  localparam exp_t E_MADDR   = '{st:4'd2, asa:1'b1, asb:2'b10, default:'0};
  localparam exp_t E_MRD     = '{st:4'd3, iod:1'b1, mrd:1'b1, default:'0};
  localparam exp_t E_MWB     = '{st:4'd4, rw:1'b1, m2r:1'b1, done:1'b1, default:'0};
  localparam exp_t E_MWR_W   = '{st:4'd5, iod:1'b1, mwr:1'b1, default:'0};
  localparam exp_t E_MWR_G   = '{st:4'd5, iod:1'b1, mwr:1'b1, done:1'b1, default:'0};
  localparam exp_t E_REX     = '{st:4'd6, asa:1'b1, aop:2'b10, default:'0};
  localparam exp_t E_RWB     = '{st:4'd7, rw:1'b1, rdst:1'b1, done:1'b1, default:'0};
  localparam exp_t E_BR_T    = '{st:4'd8, pcw:1'b1, asa:1'b1, aop:2'b01, psrc:2'b01, done:1'b1, default:'0};
  localparam exp_t E_BR_N    = '{st:4'd8, asa:1'b1, aop:2'b01, psrc:2'b01, done:1'b1, default:'0};
  localparam exp_t E_IEX     = '{st:4'd9, asa:1'b1, asb:2'b10, aop:2'b11, default:'0};
  localparam exp_t E_IWB     = '{st:4'd10, rw:1'b1, done:1'b1, default:'0};

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_BAD  = 6'h3f;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_timeout;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Monitor: one comparison per cycle the stimulus has scheduled.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e, got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {state, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
             instr_done, illegal_op, mem_timeout};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, got, e);
      end
    end
  end

  // One clock cycle of stimulus: inputs for this cycle and expected outputs.
  task automatic step(input logic r, input logic [5:0] op, input logic z,
                      input logic rd, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    reset     = r;
    opcode    = op;
    zero      = z;
    mem_ready = rd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

    // reset, two cycles
    step(1, OP_R, 0, 1, E_ZERO, "reset_c0");
    step(1, OP_R, 0, 1, E_ZERO, "reset_c1");

    // R-type, no waits: 0,1,6,7
    step(0, OP_R,   0, 1, E_FETCH_G, "r_fetch");
    step(0, OP_R,   0, 1, E_DEC,     "r_decode");
    step(0, OP_BAD, 0, 1, E_REX,     "r_exec");
    step(0, OP_BAD, 0, 1, E_RWB,     "r_wb");

    // lw with 3 wait cycles in MEM_READ: 8 cycles; opcode changes after
    // DECODE so the latched copy must steer MEM_ADDR.
    step(0, OP_LW, 0, 1, E_FETCH_G, "lw_fetch");
    step(0, OP_LW, 0, 0, E_DEC,     "lw_decode");
    step(0, OP_SW, 0, 1, E_MADDR,   "lw_addr");
    step(0, OP_SW, 0, 0, E_MRD,     "lw_read_w0");
    step(0, OP_SW, 0, 0, E_MRD,     "lw_read_w1");
    step(0, OP_SW, 0, 0, E_MRD,     "lw_read_w2");
    step(0, OP_SW, 0, 1, E_MRD,     "lw_read_go");
    step(0, OP_SW, 0, 0, E_MWB,     "lw_wb");

    // sw with one wait in MEM_WRITE
    step(0, OP_SW, 0, 1, E_FETCH_G, "sw_fetch");
    step(0, OP_SW, 0, 1, E_DEC,     "sw_decode");
    step(0, OP_LW, 0, 1, E_MADDR,   "sw_addr");
    step(0, OP_LW, 0, 0, E_MWR_W,   "sw_write_w");
    step(0, OP_LW, 0, 1, E_MWR_G,   "sw_write_go");

    // immediates
    step(0, OP_ADDI, 0, 1, E_FETCH_G, "addi_fetch");
    step(0, OP_ADDI, 0, 1, E_DEC,     "addi_decode");
    step(0, OP_ADDI, 0, 1, E_IEX,     "addi_exec");
    step(0, OP_ADDI, 0, 1, E_IWB,     "addi_wb");
    step(0, OP_ANDI, 0, 1, E_FETCH_G, "andi_fetch");
    step(0, OP_ANDI, 0, 1, E_DEC,     "andi_decode");
    step(0, OP_ANDI, 0, 1, E_IEX,     "andi_exec");
    step(0, OP_ANDI, 0, 1, E_IWB,     "andi_wb");

    // branches: beq z=1 taken, beq z=0 not, bne z=0 taken, bne z=1 not
    step(0, OP_BEQ, 0, 1, E_FETCH_G, "beq1_fetch");
    step(0, OP_BEQ, 0, 1, E_DEC,     "beq1_decode");
    step(0, OP_BNE, 1, 0, E_BR_T,    "beq1_branch");
    step(0, OP_BEQ, 0, 1, E_FETCH_G, "beq0_fetch");
    step(0, OP_BEQ, 0, 1, E_DEC,     "beq0_decode");
    step(0, OP_BEQ, 0, 1, E_BR_N,    "beq0_branch");
    step(0, OP_BNE, 0, 1, E_FETCH_G, "bne0_fetch");
    step(0, OP_BNE, 0, 1, E_DEC,     "bne0_decode");
    step(0, OP_BEQ, 0, 1, E_BR_T,    "bne0_branch");
    step(0, OP_BNE, 0, 1, E_FETCH_G, "bne1_fetch");
    step(0, OP_BNE, 0, 1, E_DEC,     "bne1_decode");
    step(0, OP_BNE, 1, 1, E_BR_N,    "bne1_branch");

    // fetch stall then illegal opcode
    step(0, OP_BAD, 0, 0, E_FETCH_W, "ill_fetch_w0");
    step(0, OP_BAD, 0, 0, E_FETCH_W, "ill_fetch_w1");
    step(0, OP_BAD, 0, 1, E_FETCH_G, "ill_fetch_go");
    step(0, OP_BAD, 0, 1, E_DEC_ILL, "ill_decode");

    // reset during a stalled MEM_WRITE drops the store
    step(0, OP_SW, 0, 1, E_FETCH_G, "rst_sw_fetch");
    step(0, OP_SW, 0, 1, E_DEC,     "rst_sw_decode");
    step(0, OP_SW, 0, 0, E_MADDR,   "rst_sw_addr");
    step(0, OP_SW, 0, 0, E_MWR_W,   "rst_sw_write_w");
    step(1, OP_SW, 0, 0, E_ZERO,    "rst_sw_in_reset");
    step(0, OP_SW, 0, 0, E_FETCH_W, "rst_sw_refetch_w");
    step(0, OP_R,  0, 1, E_FETCH_G, "rst_sw_refetch_go");
    step(0, OP_R,  0, 1, E_DEC,     "rst_sw_decode2");

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
